// File: rtl/result_bcd_pkg.sv
// Shared constants for the signed binary-to-BCD converter.
package result_bcd_pkg;

    // Converter states (legacy-compatible constant encoding)
    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SHIFT = 1'b1;

    // Width of one packed BCD digit
    localparam int BCD_W = 4;

    // Double-dabble correction: digits at or above this value get +3 before the shift
    localparam logic [BCD_W-1:0] ADD3_THRESH = 4'd5;

endpackage

// File: rtl/result_bcd_converter_digit_adj.sv
// Single-digit double-dabble correction: +3 when the digit is 5 or more.
module bcd_digit_adj
    import result_bcd_pkg::*;
(
    input  logic [BCD_W-1:0] d_in,
    output logic [BCD_W-1:0] d_out
);

    // Add 3 so the following left shift carries into the next decimal digit
    always_comb begin
        d_out = d_in;
        if (d_in >= ADD3_THRESH) begin
            d_out = d_in + 4'd3;
        end
    end

endmodule

// File: rtl/result_bcd_converter.sv
// Sequential signed binary-to-BCD converter for the seven-segment display path.
// One double-dabble iteration per cycle; results land BIN_W cycles after start.
//
// state    | meaning
// ---------|-----------------------------------------------------------
// ST_IDLE  | waiting for start; output registers hold the last result
// ST_SHIFT | one add-3/shift iteration per cycle, BIN_W iterations total
module result_bcd_converter
    import result_bcd_pkg::*;
#(
    parameter int BIN_W      = 32,
    parameter int DIGITS     = 3,
    parameter int INT_DIGITS = 10
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [BIN_W-1:0]        value,
    output logic                    ready,
    output logic                    done,
    output logic                    neg,
    output logic [BCD_W*DIGITS-1:0] bcd,
    output logic                    overflow
);

    localparam int CNT_W = $clog2(BIN_W);
    localparam int ACC_W = BCD_W * INT_DIGITS;
    localparam int OUT_W = BCD_W * DIGITS;

    logic [0:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [BIN_W-1:0] bin_q, bin_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic             sign_q, sign_d;
    logic             neg_q, neg_d;
    logic [OUT_W-1:0] bcd_q, bcd_d;
    logic             ovf_q, ovf_d;
    logic             done_q, done_d;

    logic [ACC_W-1:0] acc_adj;
    logic [ACC_W-1:0] acc_shift;

    // Per-digit add-3 correction across the whole internal accumulator
    for (genvar g = 0; g < INT_DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .d_in  (acc_q[g*BCD_W +: BCD_W]),
            .d_out (acc_adj[g*BCD_W +: BCD_W])
        );
    end

    // Next-state, datapath and output-register load logic
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bin_d     = bin_q;
        acc_d     = acc_q;
        sign_d    = sign_q;
        neg_d     = neg_q;
        bcd_d     = bcd_q;
        ovf_d     = ovf_q;
        done_d    = 1'b0;
        acc_shift = {acc_adj[ACC_W-2:0], bin_q[BIN_W-1]};

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    sign_d  = value[BIN_W-1];
                    // Magnitude is treated as unsigned, so the most negative input maps cleanly
                    bin_d   = value[BIN_W-1] ? (~value + BIN_W'(1)) : value;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                acc_d = acc_shift;
                bin_d = {bin_q[BIN_W-2:0], 1'b0};
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(BIN_W - 1)) begin
                    state_d = ST_IDLE;
                    neg_d   = sign_q;
                    bcd_d   = acc_shift[OUT_W-1:0];
                    ovf_d   = |acc_shift[ACC_W-1:OUT_W];
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            bin_q   <= '0;
            acc_q   <= '0;
            sign_q  <= 1'b0;
            neg_q   <= 1'b0;
            bcd_q   <= '0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bin_q   <= bin_d;
            acc_q   <= acc_d;
            sign_q  <= sign_d;
            neg_q   <= neg_d;
            bcd_q   <= bcd_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
        end
    end

    assign ready    = (state_q == ST_IDLE);
    assign done     = done_q;
    assign neg      = neg_q;
    assign bcd      = bcd_q;
    assign overflow = ovf_q;

endmodule
